// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared width, mode constants and control strobe bundle for the multiplier
package mult_pkg;

    localparam int MULT_N = 8;

    localparam logic MODE_LOAD  = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;
    localparam logic MODE_CLEAR = 1'b0;
    localparam logic MODE_ADD   = 1'b1;

    typedef struct packed {
        logic en_a;
        logic ld_shift_a;
        logic en_b;
        logic ld_shift_b;
        logic en_p;
        logic ld_add_p;
    } mult_ctrl_t;

endpackage

// File: rtl/mult_shift_reg.sv
// rtl/mult_shift_reg.sv - load-or-shift register with enable and synchronous clear
import mult_pkg::*;

module mult_shift_reg #(
    parameter int W          = 8,
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         mode,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            if (mode == MODE_LOAD) begin
                q_d = d_in;
            end else if (SHIFT_LEFT) begin
                q_d = {q_q[W-2:0], 1'b0};
            end else begin
                q_d = {1'b0, q_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_out = q_q;

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-add multiplier datapath with result capture and done pulse
import mult_pkg::*;

module mult_datapath #(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           en_a,
    input  logic           ld_shift_a,
    input  logic           en_b,
    input  logic           ld_shift_b,
    input  logic           en_p,
    input  logic           ld_add_p,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           zero,
    output logic           lsb_b,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);

    mult_ctrl_t     ctrl;
    logic [2*N-1:0] a_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] p_q, p_d;
    logic [2*N-1:0] product_q, product_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load_cyc;
    logic           capture;

    always_comb begin
        ctrl            = '0;
        ctrl.en_a       = en_a;
        ctrl.ld_shift_a = ld_shift_a;
        ctrl.en_b       = en_b;
        ctrl.ld_shift_b = ld_shift_b;
        ctrl.en_p       = en_p;
        ctrl.ld_add_p   = ld_add_p;
    end

    mult_shift_reg #(.W(2*N), .SHIFT_LEFT(1'b1)) u_reg_a (
        .clk   (clk),
        .clr   (clr),
        .en    (ctrl.en_a),
        .mode  (ctrl.ld_shift_a),
        .d_in  ({{N{1'b0}}, a_in}),
        .q_out (a_q)
    );

    mult_shift_reg #(.W(N), .SHIFT_LEFT(1'b0)) u_reg_b (
        .clk   (clk),
        .clr   (clr),
        .en    (ctrl.en_b),
        .mode  (ctrl.ld_shift_b),
        .d_in  (b_in),
        .q_out (b_q)
    );

    assign zero  = (b_q == '0);
    assign lsb_b = b_q[0];

    // Capture fires once the controller is idle (no enables) with B exhausted.
    always_comb begin
        load_cyc = ctrl.en_a & ctrl.en_b & ctrl.en_p
                 & (ctrl.ld_shift_a == MODE_LOAD)
                 & (ctrl.ld_shift_b == MODE_LOAD)
                 & (ctrl.ld_add_p == MODE_CLEAR);
        capture  = busy_q & zero & ~(ctrl.en_a | ctrl.en_b | ctrl.en_p);

        p_d = p_q;
        if (ctrl.en_p) begin
            p_d = (ctrl.ld_add_p == MODE_ADD) ? (p_q + a_q) : '0;
        end

        busy_d = busy_q;
        if (load_cyc) begin
            busy_d = 1'b1;
        end else if (capture) begin
            busy_d = 1'b0;
        end

        product_d = capture ? p_q : product_q;
        done_d    = capture;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            p_q       <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            p_q       <= p_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - scoreboard bench for mult_datapath driven by a controller-accurate strobe model
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        en_a = 1'b0, ld_shift_a = 1'b0;
    logic        en_b = 1'b0, ld_shift_b = 1'b0;
    logic        en_p = 1'b0, ld_add_p = 1'b0;
    logic [7:0]  a_in = '0, b_in = '0;
    logic        zero, lsb_b, done, busy;
    logic [15:0] product;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_product = '0;

    always #5 clk = ~clk;

    mult_datapath #(.N(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .en_a       (en_a),
        .ld_shift_a (ld_shift_a),
        .en_b       (en_b),
        .ld_shift_b (ld_shift_b),
        .en_p       (en_p),
        .ld_add_p   (ld_add_p),
        .a_in       (a_in),
        .b_in       (b_in),
        .zero       (zero),
        .lsb_b      (lsb_b),
        .product    (product),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobes change on the falling edge; results are read 2 units after the rising edge.
    task automatic drive(input bit ea, input bit sa, input bit eb, input bit sb,
                         input bit ep, input bit ap);
        @(negedge clk);
        en_a = ea; ld_shift_a = sa;
        en_b = eb; ld_shift_b = sb;
        en_p = ep; ld_add_p   = ap;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_flags(input string name, input logic [7:0] mb, input bit exp_busy);
        chk({name, " zero"},  zero,  (mb == 0));
        chk({name, " lsb_b"}, lsb_b, mb[0]);
        chk({name, " busy"},  busy,  exp_busy);
    endtask

    // Multiplies a*b by the controller's rules; stop_shifts >= 0 abandons the operation after that many shifts.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stop_shifts);
        logic [7:0] mb;
        int shifts;
        mb = b;
        shifts = 0;
        if (stop_shifts < 0) begin
            exp_q.push_back(16'(a) * 16'(b));
            last_product = 16'(a) * 16'(b);
        end
        a_in = a;
        b_in = b;
        drive(1, 0, 1, 0, 1, 0);
        chk_flags("load", mb, 1'b1);
        while (mb != 0) begin
            if (stop_shifts >= 0 && shifts == stop_shifts) return;
            if (mb[0]) begin
                drive(0, 0, 0, 0, 1, 1);
                chk_flags("add", mb, 1'b1);
            end
            drive(1, 1, 1, 1, 0, 0);
            mb = mb >> 1;
            shifts++;
            chk_flags("shift", mb, 1'b1);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("capture busy", busy, 1'b0);
        chk("capture product", product, last_product);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        logic [15:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected done", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("done product", product, exp);
                    chk("done busy", busy, 1'b0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #2;
        chk("reset product", product, 0);
        chk("reset done", done, 0);
        chk_flags("reset", 8'd0, 1'b0);
        @(negedge clk);
        clr = 1'b0;

        run_op(8'd13, 8'd11, -1);
        run_op(8'd200, 8'd0, -1);
        run_op(8'd255, 8'd255, -1);
        run_op(8'd3, 8'h80, -1);
        run_op(8'd0, 8'd77, -1);

        // Mode bits without enables must not disturb anything while idle.
        drive(0, 1, 0, 1, 0, 1);
        drive(0, 1, 0, 1, 0, 1);
        chk_flags("modes only", 8'd0, 1'b0);
        chk("product hold", product, last_product);

        run_op(8'd9, 8'd7, 2);
        @(negedge clk);
        clr = 1'b1;
        en_a = 0; en_b = 0; en_p = 0;
        @(posedge clk);
        #2;
        chk("midreset product", product, 0);
        chk_flags("midreset", 8'd0, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        run_op(8'd5, 8'd6, -1);

        run_op(8'd7, 8'd9, 1);
        run_op(8'd4, 8'd5, -1);

        // Simultaneous clear and load: clear wins.
        a_in = 8'd50;
        b_in = 8'd3;
        @(negedge clk);
        clr = 1'b1;
        drive(1, 0, 1, 0, 1, 0);
        chk_flags("clr+load", 8'd0, 1'b0);
        chk("clr+load product", product, 0);
        @(negedge clk);
        clr = 1'b0;
        last_product = '0;
        drive(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1);
        end

        repeat (3) drive(0, 0, 0, 0, 0, 0);
        chk("pending results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
